// File: rtl/trap_ctrl_if.sv
// Pipeline-side bundle for the machine-mode trap sequencer: EX/MEM status and CSR
// values in, pipeline-register control, fetch redirect and CSR write port out.
interface trap_ctrl_if;
   logic        ex_valid_i;
   logic        ex_trap_i;
   logic        ex_ebreak_i;
   logic        ex_mret_i;
   logic [31:0] ex_pc_i;
   logic        mem_busy_i;
   logic        irq_ext_i;
   logic        mstatus_mie_i;
   logic        mie_meie_i;
   logic [31:0] mtvec_i;
   logic [31:0] mepc_i;
   logic        flush_if_o;
   logic        flush_id_o;
   logic        flush_ex_o;
   logic        stall_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        csr_we_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;
   logic        mstatus_trap_o;
   logic        mstatus_mret_o;
   logic        busy_o;

   modport slave (
      input  ex_valid_i, ex_trap_i, ex_ebreak_i, ex_mret_i, ex_pc_i, mem_busy_i,
             irq_ext_i, mstatus_mie_i, mie_meie_i, mtvec_i, mepc_i,
      output flush_if_o, flush_id_o, flush_ex_o, stall_o, redirect_o, redirect_pc_o,
             csr_we_o, csr_waddr_o, csr_wdata_o, mstatus_trap_o, mstatus_mret_o, busy_o
   );

   modport master (
      output ex_valid_i, ex_trap_i, ex_ebreak_i, ex_mret_i, ex_pc_i, mem_busy_i,
             irq_ext_i, mstatus_mie_i, mie_meie_i, mtvec_i, mepc_i,
      input  flush_if_o, flush_id_o, flush_ex_o, stall_o, redirect_o, redirect_pc_o,
             csr_we_o, csr_waddr_o, csr_wdata_o, mstatus_trap_o, mstatus_mret_o, busy_o
   );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts ecall/ebreak/mret/external IRQ from EX, drains MEM,
// writes mepc/mcause, updates mstatus and redirects fetch to the handler or return address.
module trap_ctrl #(
   parameter int unsigned IRQ_SYNC_STAGES = 2
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   trap_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAIN    = 3'd1,
      W_EPC    = 3'd2,
      W_CAUSE  = 3'd3,
      REDIRECT = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      KIND_EXC  = 2'd0,
      KIND_IRQ  = 2'd1,
      KIND_MRET = 2'd2
   } kind_e;

   localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
   localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
   localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;

   logic [IRQ_SYNC_STAGES-1:0] irq_sync_q;
   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] cause_q, cause_d;
   logic        stall_q, redirect_q, flush_if_q, csr_we_q;
   logic [11:0] csr_waddr_q;
   logic [31:0] csr_wdata_q;
   logic        mstatus_trap_q, mstatus_mret_q, busy_q;
   logic        irq_pend_s, accept_s;
   logic [31:0] tvec_base_s, redirect_pc_s;

   // Two-or-more flop synchronizer for the asynchronous external interrupt level
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         irq_sync_q <= '0;
      end else begin
         irq_sync_q <= {irq_sync_q[IRQ_SYNC_STAGES-2:0], bus.irq_ext_i};
      end
   end

   assign irq_pend_s = irq_sync_q[IRQ_SYNC_STAGES-1] & bus.mstatus_mie_i & bus.mie_meie_i;
   assign accept_s   = (state_q == IDLE) & bus.ex_valid_i &
                       (bus.ex_trap_i | bus.ex_mret_i | irq_pend_s);

   // Next-state and request latching; priority is exception > mret > interrupt
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = DRAIN;
               epc_d   = bus.ex_pc_i;
               if (bus.ex_trap_i) begin
                  kind_d  = KIND_EXC;
                  cause_d = bus.ex_ebreak_i ? CAUSE_EBREAK : CAUSE_ECALL;
               end else if (bus.ex_mret_i) begin
                  kind_d  = KIND_MRET;
                  cause_d = 32'h0000_0000;
               end else begin
                  kind_d  = KIND_IRQ;
                  cause_d = CAUSE_IRQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (!bus.mem_busy_i) begin
               state_d = (kind_q == KIND_MRET) ? REDIRECT : W_EPC;
            end else begin
               state_d = DRAIN;
            end
         end
         W_EPC:    state_d = W_CAUSE;
         W_CAUSE:  state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // FSM state plus outputs registered from the state being entered
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q        <= IDLE;
         kind_q         <= KIND_EXC;
         epc_q          <= 32'h0000_0000;
         cause_q        <= 32'h0000_0000;
         stall_q        <= 1'b0;
         redirect_q     <= 1'b0;
         flush_if_q     <= 1'b0;
         csr_we_q       <= 1'b0;
         csr_waddr_q    <= 12'h000;
         csr_wdata_q    <= 32'h0000_0000;
         mstatus_trap_q <= 1'b0;
         mstatus_mret_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         kind_q         <= kind_d;
         epc_q          <= epc_d;
         cause_q        <= cause_d;
         stall_q        <= (state_d == DRAIN) | (state_d == W_EPC) | (state_d == W_CAUSE);
         redirect_q     <= (state_d == REDIRECT);
         flush_if_q     <= (state_d == REDIRECT);
         csr_we_q       <= (state_d == W_EPC) | (state_d == W_CAUSE);
         mstatus_trap_q <= (state_d == W_CAUSE);
         mstatus_mret_q <= (state_d == REDIRECT) & (kind_d == KIND_MRET);
         busy_q         <= (state_d != IDLE);
         case (state_d)
            W_EPC: begin
               csr_waddr_q <= CSR_MEPC;
               csr_wdata_q <= {epc_d[31:2], 2'b00};
            end
            W_CAUSE: begin
               csr_waddr_q <= CSR_MCAUSE;
               csr_wdata_q <= cause_d;
            end
            default: begin
               csr_waddr_q <= 12'h000;
               csr_wdata_q <= 32'h0000_0000;
            end
         endcase
      end
   end

   // Redirect target follows the live mtvec/mepc while the redirect strobe is up
   always_comb begin
      tvec_base_s   = {bus.mtvec_i[31:2], 2'b00};
      redirect_pc_s = 32'h0000_0000;
      if (redirect_q) begin
         case (kind_q)
            KIND_MRET: redirect_pc_s = {bus.mepc_i[31:2], 2'b00};
            KIND_IRQ: begin
               if (bus.mtvec_i[1:0] == 2'b01) begin
                  redirect_pc_s = tvec_base_s + {25'd0, cause_q[4:0], 2'b00};
               end else begin
                  redirect_pc_s = tvec_base_s;
               end
            end
            default:   redirect_pc_s = tvec_base_s;
         endcase
      end else begin
         redirect_pc_s = 32'h0000_0000;
      end
   end

   assign bus.flush_if_o     = accept_s | flush_if_q;
   assign bus.flush_id_o     = accept_s;
   assign bus.flush_ex_o     = accept_s;
   assign bus.stall_o        = stall_q;
   assign bus.redirect_o     = redirect_q;
   assign bus.redirect_pc_o  = redirect_pc_s;
   assign bus.csr_we_o       = csr_we_q;
   assign bus.csr_waddr_o    = csr_waddr_q;
   assign bus.csr_wdata_o    = csr_wdata_q;
   assign bus.mstatus_trap_o = mstatus_trap_q;
   assign bus.mstatus_mret_o = mstatus_mret_q;
   assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random stimulus, checked every cycle
// against an action-script reference model.
module tb_trap_ctrl;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rstn;
   trap_ctrl_if tif();

   trap_ctrl #(.IRQ_SYNC_STAGES(SYNC)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (tif)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: request record, pending action script, irq delay line
   int          m_mode;     // 0 idle, 1 waiting for MEM to drain, 2 running script
   int          m_kind;     // 0 exception, 1 interrupt, 2 mret
   logic [31:0] m_epc, m_cause;
   int          script[$];  // 1 write mepc, 2 write mcause, 3 redirect
   bit          hist[SYNC];

   logic        e_fif, e_fid, e_fex, e_stall, e_redir, e_we, e_mtrap, e_mret, e_busy;
   logic [11:0] e_addr;
   logic [31:0] e_rpc, e_data;

   logic        l_fex, l_stall, l_redir, l_we, l_mtrap, l_mret, l_busy;
   logic [11:0] l_addr;
   logic [31:0] l_rpc, l_data;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] target();
      logic [31:0] base;
      base = tif.mtvec_i & 32'hFFFF_FFFC;
      if (m_kind == 2) return tif.mepc_i & 32'hFFFF_FFFC;
      if (m_kind == 1 && tif.mtvec_i[1:0] == 2'b01) return base + (m_cause % 32) * 4;
      return base;
   endfunction

   function automatic bit irq_pend();
      return hist[SYNC-1] & tif.mstatus_mie_i & tif.mie_meie_i;
   endfunction

   function automatic bit accepts();
      return tif.ex_valid_i & (tif.ex_trap_i | tif.ex_mret_i | irq_pend());
   endfunction

   task automatic model_reset();
      m_mode = 0; m_kind = 0; m_epc = 0; m_cause = 0;
      script.delete();
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
   endtask

   task automatic expect_now();
      {e_fif, e_fid, e_fex, e_stall, e_redir, e_we, e_mtrap, e_mret, e_busy} = '0;
      e_addr = '0; e_rpc = '0; e_data = '0;
      if (rstn) begin
         if (m_mode == 0) begin
            e_fif = accepts(); e_fid = e_fif; e_fex = e_fif;
         end else if (m_mode == 1) begin
            e_stall = 1'b1; e_busy = 1'b1;
         end else begin
            e_busy = 1'b1;
            if (script[0] == 1) begin
               e_stall = 1'b1; e_we = 1'b1; e_addr = 12'h341; e_data = m_epc & 32'hFFFF_FFFC;
            end else if (script[0] == 2) begin
               e_stall = 1'b1; e_we = 1'b1; e_addr = 12'h342; e_data = m_cause; e_mtrap = 1'b1;
            end else begin
               e_redir = 1'b1; e_fif = 1'b1; e_rpc = target(); e_mret = (m_kind == 2);
            end
         end
      end
   endtask

   task automatic model_step();
      bit acc;
      if (!rstn) begin
         model_reset();
         return;
      end
      acc = accepts();
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = tif.irq_ext_i;
      if (m_mode == 0) begin
         if (acc) begin
            m_epc = tif.ex_pc_i;
            if (tif.ex_trap_i) begin
               m_kind = 0; m_cause = tif.ex_ebreak_i ? 32'h3 : 32'hB;
            end else if (tif.ex_mret_i) begin
               m_kind = 2; m_cause = 0;
            end else begin
               m_kind = 1; m_cause = 32'h8000_000B;
            end
            m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (!tif.mem_busy_i) begin
            if (m_kind == 2) script = '{3};
            else script = '{1, 2, 3};
            m_mode = 2;
         end
      end else begin
         void'(script.pop_front());
         if (script.size() == 0) m_mode = 0;
      end
   endtask

   // one clock: compare at the falling edge, advance the model at the rising edge
   task automatic cycle();
      @(negedge clk);
      expect_now();
      check("flush_if",     tif.flush_if_o,     e_fif);
      check("flush_id",     tif.flush_id_o,     e_fid);
      check("flush_ex",     tif.flush_ex_o,     e_fex);
      check("stall",        tif.stall_o,        e_stall);
      check("redirect",     tif.redirect_o,     e_redir);
      check("redirect_pc",  tif.redirect_pc_o,  e_rpc);
      check("csr_we",       tif.csr_we_o,       e_we);
      check("csr_waddr",    tif.csr_waddr_o,    e_addr);
      check("csr_wdata",    tif.csr_wdata_o,    e_data);
      check("mstatus_trap", tif.mstatus_trap_o, e_mtrap);
      check("mstatus_mret", tif.mstatus_mret_o, e_mret);
      check("busy",         tif.busy_o,         e_busy);
      l_fex = tif.flush_ex_o; l_stall = tif.stall_o; l_redir = tif.redirect_o;
      l_we = tif.csr_we_o; l_addr = tif.csr_waddr_o; l_data = tif.csr_wdata_o;
      l_rpc = tif.redirect_pc_o; l_mtrap = tif.mstatus_trap_o; l_mret = tif.mstatus_mret_o;
      l_busy = tif.busy_o;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      tif.ex_valid_i = 1'b0; tif.ex_trap_i = 1'b0; tif.ex_ebreak_i = 1'b0;
      tif.ex_mret_i = 1'b0; tif.ex_pc_i = 32'h0; tif.mem_busy_i = 1'b0;
   endtask

   task automatic issue(bit trap, bit ebreak, bit mret, logic [31:0] pc);
      tif.ex_valid_i = 1'b1; tif.ex_trap_i = trap; tif.ex_ebreak_i = ebreak;
      tif.ex_mret_i = mret; tif.ex_pc_i = pc;
   endtask

   initial begin
      rstn = 1'b0;
      idle_inputs();
      tif.irq_ext_i = 1'b0; tif.mstatus_mie_i = 1'b0; tif.mie_meie_i = 1'b0;
      tif.mtvec_i = 32'h0; tif.mepc_i = 32'h0;
      model_reset();
      cycle(); cycle();
      check("pin_reset_busy", l_busy, 1'b0);
      rstn = 1'b1;

      // ecall at 0x100, handler at 0x200
      tif.mtvec_i = 32'h200;
      issue(1'b1, 1'b0, 1'b0, 32'h100); cycle();
      check("pin_ecall_flush", l_fex, 1'b1);
      idle_inputs(); cycle();
      check("pin_ecall_stall", l_stall, 1'b1);
      cycle();
      check("pin_ecall_mepc_addr", l_addr, 12'h341);
      check("pin_ecall_mepc", l_data, 32'h100);
      cycle();
      check("pin_ecall_mcause", l_data, 32'hB);
      cycle();
      check("pin_ecall_redirect", l_rpc, 32'h200);
      cycle();
      check("pin_ecall_idle", l_busy, 1'b0);

      // ebreak with MEM busy for three cycles
      issue(1'b1, 1'b1, 1'b0, 32'h80); cycle();
      idle_inputs(); tif.mem_busy_i = 1'b1;
      cycle(); cycle(); cycle();
      tif.mem_busy_i = 1'b0; cycle();
      check("pin_ebreak_drain_T4", l_stall & ~l_we, 1'b1);
      cycle();
      check("pin_ebreak_mepc", l_data, 32'h80);
      cycle();
      check("pin_ebreak_mcause", l_data, 32'h3);
      cycle();
      check("pin_ebreak_redirect", l_redir, 1'b1);
      cycle();

      // vectored external interrupt
      tif.mstatus_mie_i = 1'b1; tif.mie_meie_i = 1'b1; tif.irq_ext_i = 1'b1;
      tif.mtvec_i = 32'h201;
      cycle(); cycle();
      issue(1'b0, 1'b0, 1'b0, 32'h40); cycle();
      check("pin_irq_flush", l_fex, 1'b1);
      idle_inputs(); tif.irq_ext_i = 1'b0; cycle(); cycle();
      check("pin_irq_mepc", l_data, 32'h40);
      cycle();
      check("pin_irq_mcause", l_data, 32'h8000_000B);
      check("pin_irq_mstatus_trap", l_mtrap, 1'b1);
      cycle();
      check("pin_irq_redirect", l_rpc, 32'h22C);
      cycle();

      // mret returns to mepc
      tif.mepc_i = 32'h104;
      issue(1'b0, 1'b0, 1'b1, 32'h300); cycle();
      check("pin_mret_flush", l_fex, 1'b1);
      idle_inputs(); cycle(); cycle();
      check("pin_mret_redirect", l_rpc, 32'h104);
      check("pin_mret_pulse", l_mret, 1'b1);
      check("pin_mret_no_csr", l_we, 1'b0);
      cycle();

      // masked interrupt is never accepted
      tif.mstatus_mie_i = 1'b0; tif.irq_ext_i = 1'b1;
      issue(1'b0, 1'b0, 1'b0, 32'h50);
      cycle(); cycle(); cycle(); cycle();
      check("pin_masked_irq", l_fex | l_busy, 1'b0);
      idle_inputs(); tif.mstatus_mie_i = 1'b1;
      cycle(); cycle();

      // interrupt concurrent with ecall: ecall cause wins
      issue(1'b1, 1'b0, 1'b0, 32'h60); cycle();
      idle_inputs(); tif.irq_ext_i = 1'b0;
      cycle(); cycle(); cycle();
      check("pin_irq_vs_ecall_cause", l_data, 32'hB);
      cycle(); cycle();

      // ex_valid_i low hides a trap
      tif.ex_valid_i = 1'b0; tif.ex_trap_i = 1'b1; tif.ex_pc_i = 32'h70;
      cycle(); cycle();
      check("pin_invalid_ignored", l_busy, 1'b0);
      idle_inputs();

      // reset while writing mepc, then a fresh ecall
      tif.mtvec_i = 32'h200;
      issue(1'b1, 1'b0, 1'b0, 32'h100); cycle();
      idle_inputs(); cycle();
      rstn = 1'b0; model_reset();
      cycle();
      check("pin_rst_no_csr", l_we, 1'b0);
      cycle();
      rstn = 1'b1;
      cycle(); cycle(); cycle();
      check("pin_rst_no_redirect", l_redir, 1'b0);
      issue(1'b1, 1'b0, 1'b0, 32'h120); cycle();
      check("pin_rst_reaccept", l_fex, 1'b1);
      idle_inputs();
      for (int i = 0; i < 6; i++) cycle();

      // randomized traffic
      for (int it = 0; it < 3000; it++) begin
         if ($urandom_range(0, 399) == 0) begin
            idle_inputs();
            rstn = 1'b0; model_reset();
            cycle(); cycle();
            rstn = 1'b1;
         end
         tif.ex_valid_i  = ($urandom_range(0, 9) < 6);
         tif.ex_trap_i   = ($urandom_range(0, 99) < 15);
         tif.ex_ebreak_i = $urandom_range(0, 1);
         tif.ex_mret_i   = ($urandom_range(0, 99) < 10);
         tif.ex_pc_i     = $urandom;
         tif.mem_busy_i  = ($urandom_range(0, 9) < 4);
         if ($urandom_range(0, 14) == 0) tif.irq_ext_i = ~tif.irq_ext_i;
         if ($urandom_range(0, 19) == 0) tif.mstatus_mie_i = $urandom_range(0, 1);
         if ($urandom_range(0, 19) == 0) tif.mie_meie_i = $urandom_range(0, 1);
         tif.mtvec_i = $urandom;
         tif.mepc_i  = $urandom;
         cycle();
      end

      idle_inputs();
      for (int i = 0; i < 10; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer for the 5-stage core. Watches the EX stage for ecall/ebreak/mret and a maskable external interrupt, then stalls the front of the pipeline, drains the MEM stage, writes mepc/mcause through a dedicated CSR write port, updates mstatus, and redirects fetch to the handler or the return address. It drives the flush/stall inputs of the IF/ID and ID/EX pipeline registers and the EX/MEM kill.

## Interface
- IRQ_SYNC_STAGES, 2, flops in the irq_ext_i synchronizer (>=2)
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  EX holds a real instruction (not a bubble)
- ex_trap_i  in  1  EX instruction is ecall or ebreak
- ex_ebreak_i  in  1  qualifies ex_trap_i: 1=ebreak, 0=ecall
- ex_mret_i  in  1  EX instruction is mret
- ex_pc_i  in  32  PC of the EX instruction
- mem_busy_i  in  1  MEM stage has an outstanding bus transaction
- irq_ext_i  in  1  asynchronous level external interrupt
- mstatus_mie_i, mie_meie_i  in  1 each  global / external enable
- mtvec_i, mepc_i  in  32 each  current CSR values
- flush_if_o, flush_id_o, flush_ex_o  out  1 each  zero IF/ID, ID/EX, EX/MEM registers
- stall_o  out  1  freeze PC, IF/ID, ID/EX
- redirect_o  out  1  one-cycle fetch redirect strobe
- redirect_pc_o  out  32  redirect target
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data
- mstatus_trap_o  out  1  pulse: MPIE<=MIE, MIE<=0, MPP<=M
- mstatus_mret_o  out  1  pulse: MIE<=MPIE, MPIE<=1
- busy_o  out  1  FSM not in IDLE

## Operation
- States: IDLE, DRAIN, W_EPC, W_CAUSE, REDIRECT.
- irq_pend = synced irq_ext_i & mstatus_mie_i & mie_meie_i; level-sensitive, evaluated only in IDLE.
- Accept (IDLE only, requires ex_valid_i): priority ex_trap_i > ex_mret_i > irq_pend. ex_trap_i and ex_mret_i together: trap wins. ex_valid_i=0: all requests ignored.
- Accept cycle: latch epc=ex_pc_i, kind (trap/mret), cause (ecall 0x0000000B, ebreak 0x00000003, irq 0x8000000B); assert flush_if_o, flush_id_o, flush_ex_o combinationally (EX instruction killed; interrupted one re-executes on return); go DRAIN.
- DRAIN: stall_o=1; leave when mem_busy_i=0 (checked every cycle, min 1 cycle); trap/irq -> W_EPC, mret -> REDIRECT.
- W_EPC: csr_we_o=1, addr 0x341, data {epc[31:2],2'b00}.
- W_CAUSE: csr_we_o=1, addr 0x342, data cause; mstatus_trap_o=1.
- REDIRECT: redirect_o=1, flush_if_o=1, stall_o=0; -> IDLE.
  - trap: {mtvec_i[31:2],2'b00}.
  - irq with mtvec_i[1:0]=01: base + (cause[4:0]<<2) = base+0x2C; mode 1x treated as direct.
  - mret: {mepc_i[31:2],2'b00}, mstatus_mret_o=1.
- stall_o=1 in DRAIN, W_EPC, W_CAUSE; csr_* zero when csr_we_o=0.

## Timing
- Reset: state IDLE, synchronizer and latches cleared, every output 0.
- Reset mid-sequence: immediate return to IDLE; no further CSR writes or redirect.
- Accept at cycle T; with mem_busy_i=0: DRAIN T+1, W_EPC T+2, W_CAUSE T+3, REDIRECT T+4, IDLE T+5 (next accept earliest T+5).
- mret: DRAIN T+1, REDIRECT T+2.
- Each cycle mem_busy_i stays high in DRAIN adds one cycle.
- irq_ext_i reaches irq_pend IRQ_SYNC_STAGES cycles after rising.
- mtvec_i/mepc_i sampled in REDIRECT (combinational to redirect_pc_o).

## Test plan
- ecall at pc 0x100, mtvec 0x200, mem idle -> flushes at T; writes 0x341=0x100 (T+2), 0x342=0xB (T+3); redirect 0x200 at T+4.
- ebreak at 0x80, mem_busy_i high 3 cycles after T -> DRAIN T+1..T+4, mcause=0x3 at T+6, redirect at T+7.
- irq_ext_i high, MIE=MEIE=1, ex_pc 0x40, mtvec 0x201 -> mcause 0x8000000B, mepc 0x40, redirect 0x22C, mstatus_trap_o pulse.
- mret with mepc_i 0x104 -> flushes T, redirect 0x104 and mstatus_mret_o at T+2, no csr_we_o.
- Masking: irq with MIE=0 -> no accept; irq concurrent with ecall -> cause 0xB; ex_valid_i=0 with ex_trap_i=1 -> ignored.
- rstn_i low during W_EPC -> all outputs 0, no redirect; FSM accepts new ecall after release.
